sequence_generator: RTL and testbench

- Serial frame transmitter; the transmit-side counterpart of the team's serial sequence detector.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits a fixed sync pattern, then the payload, MSB-first, one bit per clock on a single serial line.
- The downstream detector uses the sync pattern to lock onto the frame. Sits between a local data source and the serial link.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/piso_shift_reg.sv | 28 ++
 rtl/sequence_generator.sv | 143 ++++++++++++++
 tb/tb_sequence_generator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Definitions shared by the serial frame generator and the matching sequence detector,
// so both sides agree on one frame-state encoding and one sync pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } seq_state_e;

  localparam int                      SEQ_SYNC_W   = 4;
  localparam logic [SEQ_SYNC_W-1:0]   SEQ_SYNC_PAT = 4'b1011;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out register, MSB first. Load has priority over shift.
module piso_shift_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              msb_o
);

  logic [DATA_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i)       sr_d = data_i;
    else if (shift_i) sr_d = sr_q << 1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign msb_o = sr_q[DATA_W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial frame transmitter: sync pattern then payload, MSB first, one bit per clock,
// followed by a forced idle-low gap. Every output is a flop.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          SYNC_W     = SEQ_SYNC_W,
  parameter logic [31:0] SYNC_PAT   = 32'(SEQ_SYNC_PAT),
  parameter int          GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              OUT,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output seq_state_e        state_dbg
);

  // Handshake: a payload is taken on any rising edge where in_valid and in_ready are
  // both high and reset is not asserted; in_valid seen while in_ready is low is ignored.

  if (DATA_W < 1)                 begin : g_bad_data_w   $error("DATA_W must be >= 1");            end
  if (SYNC_W < 1 || SYNC_W > 32)  begin : g_bad_sync_w   $error("SYNC_W must be in 1..32");        end
  if ((SYNC_PAT >> SYNC_W) != 0)  begin : g_bad_sync_pat $error("SYNC_PAT wider than SYNC_W");     end
  if (GAP_CYCLES < 0)             begin : g_bad_gap      $error("GAP_CYCLES must be >= 0");        end

  localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
  logic             load_en, shift_en, sr_msb;

  piso_shift_reg #(.DATA_W(DATA_W)) u_piso (
    .clk_i  (clk),
    .rst_i  (reset_n),
    .load_i (load_en),
    .shift_i(shift_en),
    .data_i (in_data),
    .msb_o  (sr_msb)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_en     = 1'b0;
    shift_en    = 1'b0;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    in_ready_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          load_en = 1'b1;
          state_d = ST_SYNC;
          cnt_d   = SYNC_LAST;
        end
      end
      ST_SYNC: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = DATA_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are computed for the state being entered so they land in flops together
    // with it. The data bit is taken from the MSB while the register shifts on that edge.
    shift_en    = (state_d == ST_DATA);
    if (state_d == ST_SYNC)      out_d = 1'(SYNC_PAT >> cnt_d);
    else if (state_d == ST_DATA) out_d = sr_msb;
    out_valid_d = (state_d == ST_SYNC) || (state_d == ST_DATA);
    busy_d      = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign OUT       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: randomized payloads through a scoreboard of expected
// frame bits, plus a minimal 1-bit configuration exercised alongside.
module tb_sequence_generator;
  import seq_pkg::*;

  localparam int         DW  = 8;
  localparam int         SW  = 4;
  localparam int         GAP = 2;
  localparam logic [3:0] PAT = 4'b1011;
  localparam int         FL  = SW + DW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, in_valid, in_ready, OUT, out_valid, busy, done;
  logic [DW-1:0] in_data;
  seq_state_e    state_dbg;

  logic       m_reset, m_valid, m_ready, m_out, m_ov, m_busy, m_done;
  logic [0:0] m_data;
  seq_state_e m_state;
  bit         m_fin = 1'b0;

  sequence_generator #(
    .DATA_W(DW), .SYNC_W(SW), .SYNC_PAT(32'(PAT)), .GAP_CYCLES(GAP)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .OUT(OUT), .out_valid(out_valid), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  sequence_generator #(
    .DATA_W(1), .SYNC_W(1), .SYNC_PAT(32'd1), .GAP_CYCLES(0)
  ) u_min (
    .clk(clk), .reset_n(m_reset), .in_data(m_data), .in_valid(m_valid),
    .in_ready(m_ready), .OUT(m_out), .out_valid(m_ov), .busy(m_busy),
    .done(m_done), .state_dbg(m_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rst_edge = 1'b0;

  always @(posedge clk) begin
    cyc++;
    rst_edge = reset_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // scoreboard: each entry is {last_bit_of_frame, bit}
  logic [1:0] exp_q[$];

  task automatic push_frame(input logic [DW-1:0] d);
    logic [FL-1:0] fr;
    fr = {PAT, d};
    for (int i = FL - 1; i >= 0; i--) exp_q.push_back({(i == 0), fr[i]});
  endtask

  // monitor
  bit in_frame = 1'b0;
  bit done_due = 1'b0;
  int gap_left = -1;

  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_edge) begin
      chk("reset_outputs", 32'({OUT, out_valid, done, in_ready, busy}), 32'(5'b00010));
      chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
      exp_q.delete();
      in_frame = 1'b0;
      done_due = 1'b0;
      gap_left = -1;
    end else begin
      chk("done", 32'(done), 32'(done_due));
      done_due = 1'b0;
      if (out_valid) begin
        chk("frame_flags", 32'({busy, in_ready}), 32'(2'b10));
        if (exp_q.size() == 0) begin
          fail_now("extra_bit", "out_valid=1 required 0");
        end else begin
          e = exp_q.pop_front();
          chk("out_bit", 32'(OUT), 32'(e[0]));
          in_frame = !e[1];
          if (e[1]) begin
            done_due = 1'b1;
            gap_left = GAP;
          end
        end
      end else begin
        if (in_frame) begin
          fail_now("bubble", "out_valid=0 inside frame required 1");
          in_frame = 1'b0;
        end else if (exp_q.size() != 0) begin
          fail_now("late_start", "out_valid=0 after accept required 1");
          exp_q.delete();
        end
        chk("out_idle", 32'(OUT), 32'd0);
        if (gap_left > 0) begin
          chk("gap_flags", 32'({busy, in_ready}), 32'(2'b10));
          gap_left--;
        end else begin
          chk("idle_flags", 32'({busy, in_ready}), 32'(2'b01));
          gap_left = -1;
        end
      end
    end
  end

  // driver: offer d until taken; acc is the cycle count just before the accepting edge
  task automatic send(input logic [DW-1:0] d, input bit keep, input bit mess, output int acc);
    int guard;
    guard    = 0;
    acc      = -1;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready && !reset_n) break;
      guard++;
      if (guard > 100) begin
        fail_now("accept_timeout", "in_ready=0 for 100 cycles required 1");
        in_valid = 1'b0;
        return;
      end
    end
    acc = cyc;
    @(posedge clk);
    #1;
    push_frame(d);
    if (!keep) in_valid = 1'b0;
    if (mess) begin
      for (int i = 0; i < FL; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DW'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
    end
  endtask

  initial begin
    int a0, a1;
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    send(8'hA5, 1'b0, 1'b0, a0);
    repeat (16) @(posedge clk);
    #1;

    send(8'h00, 1'b1, 1'b0, a0);
    in_data = 8'hFF;
    send(8'hFF, 1'b0, 1'b0, a1);
    chk("b2b_spacing", 32'(a1 - a0), 32'(FL + GAP + 1));
    repeat (16) @(posedge clk);
    #1;

    send(8'h69, 1'b0, 1'b1, a0);

    send(8'hC3, 1'b0, 1'b0, a0);
    repeat (SW + 2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    send(8'h3C, 1'b0, 1'b0, a0);

    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      send(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)), a0);
    end

    repeat (30) @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    chk("min_test_finished", 32'(m_fin), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // minimal configuration: 1-bit sync, 1-bit payload, no gap
  initial begin
    logic b;
    m_reset = 1'b1;
    m_valid = 1'b0;
    m_data  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_reset = 1'b0;
    @(negedge clk);
    chk("min_reset", 32'({m_out, m_ov, m_done, m_ready, m_busy}), 32'(5'b00010));
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      m_valid = 1'b1;
      m_data  = b;
      @(negedge clk);
      chk("min_ready", 32'(m_ready), 32'd1);
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      m_data  = ~b;
      @(negedge clk);
      chk("min_sync_bit", 32'({m_out, m_ov, m_done}), 32'(3'b110));
      @(negedge clk);
      chk("min_data_bit", 32'({m_out, m_ov, m_done}), 32'({b, 2'b10}));
      @(negedge clk);
      chk("min_done", 32'({m_out, m_ov, m_done, m_ready, m_busy}), 32'(5'b00110));
      @(negedge clk);
      chk("min_done_once", 32'({m_ov, m_done}), 32'd0);
    end
    m_fin = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
